ret_addr_stack: RTL and testbench

Hardware return-address stack for the MIPS core: it serves the stack push and pop requests that the control decode raises for JAL and JS. JAL pushes the link address (PC+4) on the cycle it is decoded. JS pops the most recent address, and the PC mux selects it as the jump target. The block sits beside the PC register, between control decode and the next-PC mux. It replaces the data-memory path for return addresses.

---
 rtl/ret_addr_stack_pkg.sv | 32 +++
 rtl/ret_addr_stack_if.sv | 28 ++
 rtl/ret_addr_stack_regfile.sv | 25 ++
 rtl/ret_addr_stack.sv | 101 ++++++++++
 tb/tb_ret_addr_stack.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/ret_addr_stack_pkg.sv
// Shared defaults and the per-cycle operation decode for the return-address stack.
// The operation is decoded once per cycle from the enabled push/pop requests and the empty state.
package ras_pkg;

   localparam int RAS_DEPTH_DEF = 8;
   localparam int RAS_AW_DEF    = 32;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      PUSH = 2'd1,
      POP  = 2'd2,
      REPL = 2'd3
   } ras_op_t;

   // A push+pop on an empty stack degenerates to a plain push.
   // A pop on an empty stack does nothing to the stack state.
   function automatic ras_op_t ras_decode(input logic en, input logic push,
                                          input logic pop, input logic empty);
      ras_op_t op;
      op = NONE;
      if (en) begin
         unique case ({push, pop})
            2'b10:   op = PUSH;
            2'b01:   op = empty ? NONE : POP;
            2'b11:   op = empty ? PUSH : REPL;
            default: op = NONE;
         endcase
      end
      return op;
   endfunction

endpackage

// File: rtl/ret_addr_stack_if.sv
// Request/status bundle between control decode / PC mux (master) and the return-address stack (slave).
interface ret_addr_stack_if
   import ras_pkg::*;
#(
   parameter int DEPTH = RAS_DEPTH_DEF,
   parameter int AW    = RAS_AW_DEF
);
   logic                      en;
   logic                      push;
   logic                      pop;
   logic [AW-1:0]             push_addr;
   logic [AW-1:0]             top_addr;
   logic [$clog2(DEPTH):0]    count;
   logic                      empty;
   logic                      full;
   logic                      overflow;
   logic                      underflow;

   modport master (
      output en, push, pop, push_addr,
      input  top_addr, count, empty, full, overflow, underflow
   );

   modport slave (
      input  en, push, pop, push_addr,
      output top_addr, count, empty, full, overflow, underflow
   );
endinterface

// File: rtl/ret_addr_stack_regfile.sv
// Return-address storage: one synchronous write port, one asynchronous read port, no reset.
module ras_regfile
   import ras_pkg::*;
#(
   parameter int DEPTH = RAS_DEPTH_DEF,
   parameter int AW    = RAS_AW_DEF
) (
   input  logic                       clk,
   input  logic                       we,
   input  logic [$clog2(DEPTH)-1:0]   waddr,
   input  logic [AW-1:0]              wdata,
   input  logic [$clog2(DEPTH)-1:0]   raddr,
   output logic [AW-1:0]              rdata
);
   logic [AW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read is combinational so the PC mux sees the pop target in the decode cycle.
   assign rdata = mem[raddr];
endmodule

// File: rtl/ret_addr_stack.sv
// Return-address stack for JAL/JS. Define RAS_WRAP_EN to make a push on full overwrite
// the oldest entry (circular); otherwise such a push is dropped. Both cases set overflow.
module ret_addr_stack
   import ras_pkg::*;
#(
   parameter int DEPTH = RAS_DEPTH_DEF,
   parameter int AW    = RAS_AW_DEF
) (
   input  logic             Clock,
   input  logic             Reset,
   ret_addr_stack_if.slave  ras
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] tp_q, tp_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          underflow_q, underflow_d;

   logic          empty, full;
   logic [PW-1:0] top_idx;
   logic          we;
   logic [PW-1:0] waddr;
   logic [AW-1:0] rdata;
   ras_op_t       op;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign top_idx = tp_q - PW'(1);
   assign op      = ras_decode(ras.en, ras.push, ras.pop, empty);

   always_comb begin
      tp_d        = tp_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      we          = 1'b0;
      waddr       = tp_q;
      unique case (op)
         PUSH: begin
            if (!full) begin
               we      = 1'b1;
               tp_d    = tp_q + PW'(1);
               count_d = count_q + CW'(1);
            end else begin
`ifdef RAS_WRAP_EN
               we   = 1'b1;
               tp_d = tp_q + PW'(1);
`endif
               overflow_d = 1'b1;
            end
         end
         POP: begin
            tp_d    = tp_q - PW'(1);
            count_d = count_q - CW'(1);
         end
         REPL: begin
            we    = 1'b1;
            waddr = top_idx;
         end
         default: ;
      endcase
      if (ras.en && ras.pop && empty) begin
         underflow_d = 1'b1;
      end
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         tp_q        <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         tp_q        <= tp_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   ras_regfile #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_regfile (
      .clk   (Clock),
      .we    (we && Reset),
      .waddr (waddr),
      .wdata (ras.push_addr),
      .raddr (top_idx),
      .rdata (rdata)
   );

   assign ras.top_addr  = empty ? '0 : rdata;
   assign ras.count     = count_q;
   assign ras.empty     = empty;
   assign ras.full      = full;
   assign ras.overflow  = overflow_q;
   assign ras.underflow = underflow_q;
endmodule

// File: tb/tb_ret_addr_stack.sv
// Directed plus randomized bench for ret_addr_stack (DEPTH=4) against a queue-based stack model.
module tb_ret_addr_stack;
   localparam int DEPTH = 4;
   localparam int AW    = 32;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   logic [AW-1:0] mq[$];
   bit            m_ovf = 1'b0;
   bit            m_unf = 1'b0;

   ret_addr_stack_if #(.DEPTH(DEPTH), .AW(AW)) ras_if ();

   ret_addr_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
      .Clock (clk),
      .Reset (rst_n),
      .ras   (ras_if.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      logic [AW-1:0] exp_top;
      exp_top = (mq.size() > 0) ? mq[mq.size()-1] : '0;
      chk({tag, ".top"},   ras_if.top_addr, exp_top);
      chk({tag, ".count"}, AW'(ras_if.count), AW'(mq.size()));
      chk({tag, ".empty"}, AW'(ras_if.empty), AW'(mq.size() == 0));
      chk({tag, ".full"},  AW'(ras_if.full), AW'(mq.size() == DEPTH));
      chk({tag, ".ovf"},   AW'(ras_if.overflow), AW'(m_ovf));
      chk({tag, ".unf"},   AW'(ras_if.underflow), AW'(m_unf));
      $display("[%0t] %s en=%0b push=%0b pop=%0b addr=%08h -> top=%08h count=%0d ovf=%0b unf=%0b",
               $time, tag, ras_if.en, ras_if.push, ras_if.pop, ras_if.push_addr,
               ras_if.top_addr, ras_if.count, ras_if.overflow, ras_if.underflow);
   endtask

   // One clock: drive, advance the model by the stack rules, then compare after the edge.
   task automatic cycle(input string tag, input bit r, input bit e, input bit pu,
                        input bit po, input logic [AW-1:0] a);
      rst_n            = r;
      ras_if.en        = e;
      ras_if.push      = pu;
      ras_if.pop       = po;
      ras_if.push_addr = a;
      @(posedge clk);
      if (!r) begin
         mq.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else if (e) begin
         if (pu && po && mq.size() > 0) begin
            mq[mq.size()-1] = a;
         end else if (pu) begin
            if (po) m_unf = 1'b1;
            if (mq.size() < DEPTH) begin
               mq.push_back(a);
            end else begin
               m_ovf = 1'b1;
`ifdef RAS_WRAP_EN
               void'(mq.pop_front());
               mq.push_back(a);
`endif
            end
         end else if (po) begin
            if (mq.size() > 0) void'(mq.pop_back());
            else m_unf = 1'b1;
         end
      end
      #1;
      check_model(tag);
   endtask

   localparam logic [AW-1:0] A = 32'h0000_A000, B = 32'h0000_B000, C = 32'h0000_C000;
   localparam logic [AW-1:0] D = 32'h0000_D000, E = 32'h0000_E000, X = 32'h0000_0F0F;

   initial begin
      rst_n = 1'b0;
      ras_if.en = 1'b1; ras_if.push = 1'b0; ras_if.pop = 1'b0; ras_if.push_addr = '0;

      // Reset held with a push request
      cycle("rst0", 0, 1, 1, 0, 32'hDEAD_BEEF);
      cycle("rst1", 0, 1, 1, 0, 32'hDEAD_BEEF);
      chk("rst.empty", AW'(ras_if.empty), 1);
      chk("rst.count", AW'(ras_if.count), 0);
      chk("rst.top",   ras_if.top_addr, 0);
      chk("rst.ovf",   AW'(ras_if.overflow), 0);
      chk("rst.unf",   AW'(ras_if.underflow), 0);

      // LIFO order
      cycle("lifo.push1", 1, 1, 1, 0, 32'h0040_0004);
      cycle("lifo.push2", 1, 1, 1, 0, 32'h0040_0010);
      chk("lifo.top2", ras_if.top_addr, 32'h0040_0010);
      chk("lifo.cnt2", AW'(ras_if.count), 2);
      cycle("lifo.pop1", 1, 1, 0, 1, '0);
      chk("lifo.top1", ras_if.top_addr, 32'h0040_0004);
      chk("lifo.cnt1", AW'(ras_if.count), 1);
      cycle("lifo.pop2", 1, 1, 0, 1, '0);
      chk("lifo.empty", AW'(ras_if.empty), 1);

      // Underflow is sticky
      cycle("unf.pop", 1, 1, 0, 1, '0);
      chk("unf.cnt", AW'(ras_if.count), 0);
      chk("unf.flag", AW'(ras_if.underflow), 1);
      cycle("unf.idle", 1, 1, 0, 0, '0);
      chk("unf.sticky", AW'(ras_if.underflow), 1);
      cycle("unf.push", 1, 1, 1, 0, 32'h0000_0100);
      chk("unf.top", ras_if.top_addr, 32'h0000_0100);
      chk("unf.still", AW'(ras_if.underflow), 1);

      // Full behaviour
      cycle("full.rst", 0, 1, 0, 0, '0);
      cycle("full.A", 1, 1, 1, 0, A);
      cycle("full.B", 1, 1, 1, 0, B);
      cycle("full.C", 1, 1, 1, 0, C);
      cycle("full.D", 1, 1, 1, 0, D);
      chk("full.flag", AW'(ras_if.full), 1);
      chk("full.noovf", AW'(ras_if.overflow), 0);
      cycle("full.E", 1, 1, 1, 0, E);
      chk("full.cnt", AW'(ras_if.count), 4);
      chk("full.ovf", AW'(ras_if.overflow), 1);
`ifdef RAS_WRAP_EN
      chk("full.top", ras_if.top_addr, E);
      cycle("full.pop1", 1, 1, 0, 1, '0); chk("full.popD", ras_if.top_addr, D);
      cycle("full.pop2", 1, 1, 0, 1, '0); chk("full.popC", ras_if.top_addr, C);
      cycle("full.pop3", 1, 1, 0, 1, '0); chk("full.popB", ras_if.top_addr, B);
`else
      chk("full.top", ras_if.top_addr, D);
      cycle("full.pop1", 1, 1, 0, 1, '0); chk("full.popC", ras_if.top_addr, C);
      cycle("full.pop2", 1, 1, 0, 1, '0); chk("full.popB", ras_if.top_addr, B);
      cycle("full.pop3", 1, 1, 0, 1, '0); chk("full.popA", ras_if.top_addr, A);
`endif
      cycle("full.pop4", 1, 1, 0, 1, '0);
      chk("full.empty", AW'(ras_if.empty), 1);

      // Replace top
      cycle("repl.rst", 0, 1, 0, 0, '0);
      cycle("repl.A", 1, 1, 1, 0, A);
      cycle("repl.B", 1, 1, 1, 0, B);
      cycle("repl.X", 1, 1, 1, 1, X);
      chk("repl.top", ras_if.top_addr, X);
      chk("repl.cnt", AW'(ras_if.count), 2);
      chk("repl.noovf", AW'(ras_if.overflow), 0);
      cycle("repl.pop", 1, 1, 0, 1, '0);
      chk("repl.topA", ras_if.top_addr, A);

      // Stall, then reset wins over a push
      cycle("stall.push", 1, 0, 1, 0, C);
      cycle("stall.pop", 1, 0, 0, 1, '0);
      chk("stall.top", ras_if.top_addr, A);
      chk("stall.cnt", AW'(ras_if.count), 1);
      cycle("rw.B", 1, 1, 1, 0, B);
      cycle("rw.C", 1, 1, 1, 0, C);
      chk("rw.cnt3", AW'(ras_if.count), 3);
      cycle("rw.rst", 0, 1, 1, 0, D);
      chk("rw.cnt", AW'(ras_if.count), 0);
      chk("rw.empty", AW'(ras_if.empty), 1);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         cycle("rand", ($urandom_range(99) >= 2), ($urandom_range(99) < 80),
               $urandom_range(1), $urandom_range(1), $urandom());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
